// File: rtl/heart_rate_monitor.sv
// heart_rate_monitor
//   Counts rising edges of a synchronous beat level over fixed windows of
//   WINDOW clk cycles. At the end of each window the count is latched and
//   classified against the NORM +/- TOL band. An alarm is raised after
//   ALARM_N consecutive out-of-band windows.
//
// Ports
//   clk          : rising-edge clock
//   reset        : asynchronous, active-high reset
//   enable       : run continuous measurement windows
//   beat         : synchronous beat level (each 0->1 transition is one beat)
//   beat_count   : live beat count for the current window (saturating)
//   window_count : cycle index within the current window
//   result       : latched beat count of the last completed window
//   deviation    : |result - NORM|
//   too_low      : result below the (floor-saturated) lower band limit
//   too_high     : result above the (ceiling-saturated) upper band limit
//   in_band      : neither too_low nor too_high
//   result_valid : one-cycle pulse during the evaluation cycle
//   alarm        : sticky out-of-band alarm, cleared by an in-band window
module heart_rate_monitor #(
  parameter int unsigned W       = 8,
  parameter int unsigned WINDOW  = 200,
  parameter int unsigned NORM    = 100,
  parameter int unsigned TOL     = 10,
  parameter int unsigned ALARM_N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         beat,
  output logic [W-1:0] beat_count,
  output logic [15:0]  window_count,
  output logic [W-1:0] result,
  output logic [W-1:0] deviation,
  output logic         too_low,
  output logic         too_high,
  output logic         in_band,
  output logic         result_valid,
  output logic         alarm
);

  localparam longint unsigned MAX_V = (64'd1 << W) - 64'd1;
  localparam longint unsigned LO_V  = (NORM > TOL) ? 64'(NORM - TOL) : 64'd0;
  localparam longint unsigned HI_V  =
    ((64'(NORM) + 64'(TOL)) > MAX_V) ? MAX_V : (64'(NORM) + 64'(TOL));

  localparam logic [W-1:0] LO_TH    = W'(LO_V);
  localparam logic [W-1:0] HI_TH    = W'(HI_V);
  localparam logic [W-1:0] NORM_W   = W'(NORM);
  localparam logic [W-1:0] CNT_MAX  = '1;
  localparam logic [15:0]  WIN_LAST = 16'(WINDOW - 1);
  localparam logic [3:0]   ALARM_C  = 4'(ALARM_N);
  localparam logic         RST_LOW  = (NORM > TOL);

  typedef enum logic [1:0] {IDLE, COUNT, EVAL} state_t;

  state_t       state;
  logic         beat_prev;
  logic         beat_edge;
  logic [W-1:0] count_next;
  logic [W-1:0] dev_next;
  logic         low_next;
  logic         high_next;
  logic [3:0]   oob_cnt;
  logic [3:0]   oob_inc;

  // count_next already includes an edge seen on the last window cycle, so
  // the classification below always reflects the final count of the window.
  always_comb begin
    beat_edge  = beat & ~beat_prev;
    count_next = beat_count;
    if (beat_edge && (beat_count != CNT_MAX))
      count_next = beat_count + W'(1);
    low_next  = (count_next < LO_TH);
    high_next = (count_next > HI_TH);
    dev_next  = (count_next >= NORM_W) ? (count_next - NORM_W)
                                       : (NORM_W - count_next);
    oob_inc   = (oob_cnt >= ALARM_C) ? oob_cnt : (oob_cnt + 4'd1);
  end

  // The result registers and result_valid are loaded on the edge that enters
  // EVAL, so they are all visible together during the single EVAL cycle.
  // The live counters read 0 in EVAL; an edge seen in EVAL seeds the next
  // window's beat_count with 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beat_prev    <= 1'b0;
      beat_count   <= '0;
      window_count <= '0;
      result       <= '0;
      deviation    <= NORM_W;
      too_low      <= RST_LOW;
      too_high     <= 1'b0;
      in_band      <= ~RST_LOW;
      result_valid <= 1'b0;
      oob_cnt      <= '0;
      alarm        <= 1'b0;
    end else begin
      beat_prev    <= beat;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          beat_count   <= '0;
          window_count <= '0;
          if (enable) state <= COUNT;
        end
        COUNT: begin
          if (!enable) begin
            state        <= IDLE;
            beat_count   <= '0;
            window_count <= '0;
          end else if (window_count == WIN_LAST) begin
            state        <= EVAL;
            beat_count   <= '0;
            window_count <= '0;
            result       <= count_next;
            deviation    <= dev_next;
            too_low      <= low_next;
            too_high     <= high_next;
            in_band      <= ~(low_next | high_next);
            result_valid <= 1'b1;
            if (low_next || high_next) begin
              oob_cnt <= oob_inc;
              if (oob_inc == ALARM_C) alarm <= 1'b1;
            end else begin
              oob_cnt <= '0;
              alarm   <= 1'b0;
            end
          end else begin
            beat_count   <= count_next;
            window_count <= window_count + 16'd1;
          end
        end
        EVAL: begin
          window_count <= '0;
          if (enable) begin
            state      <= COUNT;
            beat_count <= W'(beat_edge);
          end else begin
            state      <= IDLE;
            beat_count <= '0;
          end
        end
        default: begin
          state        <= IDLE;
          beat_count   <= '0;
          window_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_heart_rate_monitor.sv
// Self-checking bench for heart_rate_monitor. Expected values come from a
// per-window model: edges are counted from the beat pattern applied to each
// window, then classified against the band and fed to an alarm counter.
module tb_heart_rate_monitor;

  localparam int W    = 8;
  localparam int WIN  = 20;
  localparam int NORM = 10;
  localparam int TOL  = 2;
  localparam int AN   = 2;
  localparam int WIN4 = 40;

  logic        clk, reset, enable, beat;
  logic [7:0]  beat_count, result, deviation;
  logic [15:0] window_count;
  logic        too_low, too_high, in_band, result_valid, alarm;

  logic        enable4, beat4;
  logic [3:0]  beat_count4, result4, deviation4;
  logic [15:0] window_count4;
  logic        too_low4, too_high4, in_band4, result_valid4, alarm4;

  bit clk_run;

  heart_rate_monitor #(.W(W), .WINDOW(WIN), .NORM(NORM), .TOL(TOL), .ALARM_N(AN)) dut (
    .clk(clk), .reset(reset), .enable(enable), .beat(beat),
    .beat_count(beat_count), .window_count(window_count), .result(result),
    .deviation(deviation), .too_low(too_low), .too_high(too_high),
    .in_band(in_band), .result_valid(result_valid), .alarm(alarm)
  );

  heart_rate_monitor #(.W(4), .WINDOW(WIN4), .NORM(10), .TOL(2), .ALARM_N(AN)) dut4 (
    .clk(clk), .reset(reset), .enable(enable4), .beat(beat4),
    .beat_count(beat_count4), .window_count(window_count4), .result(result4),
    .deviation(deviation4), .too_low(too_low4), .too_high(too_high4),
    .in_band(in_band4), .result_valid(result_valid4), .alarm(alarm4)
  );

  always #5 if (clk_run) clk = ~clk;

  int unsigned vectors;
  int unsigned miscompares;

  // model state
  bit pat [0:WIN];
  bit prev;
  int carry;
  int res_m, dev_m, oob_m;
  bit lo_m, hi_m, alarm_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    res_m = 0; dev_m = NORM; lo_m = (NORM > TOL); hi_m = 0;
    oob_m = 0; alarm_m = 0; prev = 0; carry = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bcount"}, 32'(beat_count), 0);
    check({tag, "_wcount"}, 32'(window_count), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_dev"},    32'(deviation), NORM);
    check({tag, "_low"},    32'(too_low), 1);
    check({tag, "_high"},   32'(too_high), 0);
    check({tag, "_inband"}, 32'(in_band), 0);
    check({tag, "_valid"},  32'(result_valid), 0);
    check({tag, "_alarm"},  32'(alarm), 0);
  endtask

  // From IDLE: the edge that samples enable=1 starts the window.
  task automatic start_count();
    enable = 1; beat = 0; prev = 0; carry = 0;
    tick();
  endtask

  // Runs one full window from its first COUNT cycle through EVAL.
  task automatic run_window(input bit nxt_en);
    int edges;
    bit e;
    edges = carry;
    for (int i = 0; i < WIN; i++) begin
      check("wcount", 32'(window_count), i);
      check("bcount", 32'(beat_count), (edges > 255) ? 255 : edges);
      beat = pat[i];
      if (pat[i] && !prev) edges++;
      prev = pat[i];
      tick();
    end
    res_m = (edges > 255) ? 255 : edges;
    dev_m = (res_m >= NORM) ? res_m - NORM : NORM - res_m;
    lo_m  = (res_m < NORM - TOL);
    hi_m  = (res_m > NORM + TOL);
    if (lo_m || hi_m) begin
      if (oob_m < AN) oob_m++;
      if (oob_m == AN) alarm_m = 1;
    end else begin
      oob_m = 0; alarm_m = 0;
    end
    check("eval_valid",  32'(result_valid), 1);
    check("eval_result", 32'(result), res_m);
    check("eval_dev",    32'(deviation), dev_m);
    check("eval_low",    32'(too_low), 32'(lo_m));
    check("eval_high",   32'(too_high), 32'(hi_m));
    check("eval_inband", 32'(in_band), 32'(!(lo_m || hi_m)));
    check("eval_alarm",  32'(alarm), 32'(alarm_m));
    beat = pat[WIN];
    enable = nxt_en;
    e = pat[WIN] && !prev;
    prev = pat[WIN];
    tick();
    carry = (nxt_en && e) ? 1 : 0;
    check("post_valid", 32'(result_valid), 0);
  endtask

  task automatic make_pulses(input int n);
    for (int i = 0; i <= WIN; i++) pat[i] = 0;
    for (int k = 0; k < n; k++) pat[2*k+1] = 1;
  endtask

  task automatic make_random();
    int style, k;
    style = $urandom_range(0, 1);
    k = $urandom_range(3, 10);
    for (int i = 0; i < WIN; i++)
      pat[i] = (style == 1) ? ($urandom_range(0, 1) == 1)
                            : ((i % 2 == 1) && ($urandom_range(0, 9) < k));
    pat[WIN] = ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int edges4;
    bit en;
    vectors = 0; miscompares = 0;
    clk = 0; clk_run = 1;
    reset = 1; enable = 0; beat = 0; enable4 = 0; beat4 = 0;
    model_reset();

    // reset takes effect before any clock edge
    #1;
    check_reset_values("rst0");
    tick(); tick();
    reset = 0;
    tick();

    // beats in IDLE are ignored
    for (int i = 0; i < 4; i++) begin
      beat = (i % 2 == 0);
      tick();
      check("idle_bcount", 32'(beat_count), 0);
      check("idle_wcount", 32'(window_count), 0);
      check("idle_valid",  32'(result_valid), 0);
    end

    // beat held high for the whole window -> 1
    start_count();
    for (int i = 0; i <= WIN; i++) pat[i] = 1;
    run_window(1);
    check("held_result", 32'(result), 1);

    // toggling -> 10 edges, deviation 0
    for (int i = 0; i < WIN; i++) pat[i] = (i % 2 == 1);
    pat[WIN] = 0;
    run_window(1);
    check("toggle_dev", 32'(deviation), 0);

    // edge in the EVAL cycle carries into the next window
    for (int i = 0; i <= WIN; i++) pat[i] = (i % 2 == 0);
    run_window(1);
    check("carry_in", 32'(beat_count), 1);

    // edge on window_count=19 plus carried edge -> 11
    for (int i = 0; i < WIN; i++) pat[i] = (i % 2 == 1);
    pat[WIN] = 0;
    run_window(1);
    check("eleven_result", 32'(result), 11);

    // consecutive low windows raise the alarm; in-band clears it
    make_pulses(5);
    run_window(1);
    make_pulses(4);
    run_window(1);
    check("alarm_set", 32'(alarm), 1);
    make_pulses(10);
    run_window(1);
    check("alarm_clr", 32'(alarm), 0);

    // randomized windows
    for (int w = 0; w < 8; w++) begin
      make_random();
      en = (w == 7) ? 1'b0 : ($urandom_range(0, 3) != 0);
      run_window(en);
      if (!en && w < 7) start_count();
    end

    // abort: enable dropped at window_count=7
    start_count();
    for (int i = 0; i < 7; i++) begin
      beat = ($urandom_range(0, 1) == 1);
      tick();
    end
    check("abort_wc7", 32'(window_count), 7);
    enable = 0; beat = 1;
    tick();
    check("abort_bcount", 32'(beat_count), 0);
    check("abort_wcount", 32'(window_count), 0);
    check("abort_result", 32'(result), res_m);
    check("abort_dev",    32'(deviation), dev_m);
    check("abort_low",    32'(too_low), 32'(lo_m));
    check("abort_high",   32'(too_high), 32'(hi_m));
    check("abort_alarm",  32'(alarm), 32'(alarm_m));
    for (int i = 0; i < WIN + 4; i++) begin
      beat = (i % 3 == 0);
      tick();
      check("abort_novalid", 32'(result_valid), 0);
      check("abort_idle_bc", 32'(beat_count), 0);
    end

    // two out-of-band windows so result/alarm are nonzero before reset
    start_count();
    make_pulses(3);
    run_window(1);
    make_pulses(3);
    run_window(1);
    check("pre_rst_alarm", 32'(alarm), 1);

    // reset pulse mid-window with the clock stopped
    for (int i = 0; i < 5; i++) begin
      beat = (i % 2 == 1);
      tick();
    end
    clk_run = 0;
    enable = 0; beat = 0;
    #2 reset = 1;
    #1;
    check_reset_values("rst_mid");
    #2 reset = 0;
    #1;
    check_reset_values("rst_rel");
    clk_run = 1;
    model_reset();
    for (int i = 0; i < WIN + 4; i++) begin
      tick();
      check("rst_novalid", 32'(result_valid), 0);
    end

    // recovery: a single low window must not alarm after counter reset
    start_count();
    make_pulses(2);
    run_window(0);
    check("post_rst_alarm", 32'(alarm), 0);

    // W=4 instance: 20 edges in a 40-cycle window saturate at 15
    enable4 = 1; beat4 = 0;
    tick();
    edges4 = 0;
    for (int i = 0; i < WIN4; i++) begin
      check("w4_bcount", 32'(beat_count4), (edges4 > 15) ? 15 : edges4);
      beat4 = (i % 2 == 1);
      if (i % 2 == 1) edges4++;
      tick();
    end
    check("w4_valid",  32'(result_valid4), 1);
    check("w4_result", 32'(result4), 15);
    check("w4_high",   32'(too_high4), 1);
    check("w4_dev",    32'(deviation4), 5);
    enable4 = 0; beat4 = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/heart_rate_monitor.md
HEART_RATE_MONITOR -- requirements
Module: heart_rate_monitor

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- W, 8: width of the beat counter, deviation and result.
- WINDOW, 200: measurement window length in clk cycles; legal range 2..2^16.
- NORM, 100: expected beats per window; must be less than 2^W.
- TOL, 10: half-width of the tolerance band in beats.
- ALARM_N, 3: number of consecutive out-of-band windows that raises alarm; legal range 1..15.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, input, 1: single clock; all logic is on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: run continuous measurement windows.
- beat, input, 1: synchronous beat level; each rising edge is one beat.
- beat_count, output, W: live count for the current window.
- window_count, output, 16: cycle index within the current window.
- result, output, W: latched beat count of the last completed window.
- deviation, output, W: absolute value of result - NORM.
- too_low, output, 1: result < NORM - TOL; the comparison saturates at 0.
- too_high, output, 1: result > NORM + TOL; the comparison saturates at 2^W - 1.
- in_band, output, 1: neither too_low nor too_high.
- result_valid, output, 1: one-cycle pulse when the result registers update.
- alarm, output, 1: sticky out-of-band alarm.

Function
REQ-003 The block SHALL detect a beat as beat=1 in the current cycle while the registered previous beat=0; a beat held high counts once.
REQ-004 The block SHALL implement the states IDLE, COUNT and EVAL.
- IDLE -> COUNT on enable=1.
- COUNT -> EVAL when window_count = WINDOW-1.
- EVAL -> COUNT if enable=1; EVAL -> IDLE otherwise.
REQ-005 In COUNT, window_count SHALL increment by 1 each cycle, starting at 0.
REQ-006 In COUNT, beat_count SHALL increment on each detected edge and saturate at 2^W-1 without wrapping.
REQ-007 An edge detected on the cycle where window_count = WINDOW-1 SHALL be included in that window.
REQ-008 The EVAL state SHALL last exactly one cycle, and in it the block SHALL:
- load result with the final beat_count;
- update deviation, too_low, too_high and in_band;
- assert result_valid for that cycle only;
- clear beat_count and window_count.
REQ-009 An edge detected during EVAL SHALL be counted as the first beat of the next window, so beat_count = 1 on entry to COUNT; if the next state is IDLE, that edge is dropped.
REQ-010 Result latency SHALL be WINDOW+1 cycles from the first COUNT cycle to the result_valid pulse, and consecutive windows SHALL repeat every WINDOW+1 cycles.
REQ-011 deviation, too_low, too_high and in_band SHALL be registered and SHALL change only in EVAL or on reset.
REQ-012 Exactly one of too_low, in_band and too_high SHALL be 1 after the first EVAL.
REQ-013 A 4-bit out-of-band counter SHALL behave as follows in EVAL:
- increment, saturating at ALARM_N, on an out-of-band window;
- clear on an in-band window.
REQ-014 alarm SHALL set in the EVAL cycle in which the out-of-band counter reaches ALARM_N, and SHALL stay set until an in-band EVAL or reset.
REQ-015 If enable=0 during COUNT, the block SHALL abort the window on the next edge:
- go to IDLE and clear beat_count and window_count;
- generate no result_valid;
- leave result, flags, the out-of-band counter and alarm unchanged.
REQ-016 In IDLE, beat edges SHALL be ignored and beat_count and window_count SHALL stay 0.

Reset
REQ-017 Asserting reset SHALL take effect immediately, regardless of clk.
REQ-018 Reset SHALL force the following values:
- state = IDLE;
- beat_count, window_count, result and the out-of-band counter = 0;
- deviation = NORM truncated to W bits;
- too_low = 1 only if NORM > TOL, otherwise 0;
- too_high = 0;
- in_band = NOT too_low;
- result_valid = 0;
- alarm = 0;
- registered previous beat = 0.
REQ-019 A reset asserted mid-window SHALL discard the partial window with no result_valid pulse.
REQ-020 After reset release, the first COUNT cycle SHALL follow the first clk edge that samples enable=1.

Verification
Every scenario uses W=8, WINDOW=20, NORM=10, TOL=2 and ALARM_N=2.
REQ-021 11 beat edges in a window -> result_valid on cycle 21, result=11, deviation=1, in_band=1, alarm=0.
REQ-022 5 edges in window 1, then 4 edges in window 2 ->
- after window 1: too_low=1, deviation=5, alarm=0;
- after window 2: deviation=6, alarm=1;
- a following window with 10 edges -> in_band=1 and alarm=0.
REQ-023 beat held high for the whole window -> result=1; beat toggling every cycle (10 edges) -> result=10, deviation=0.
REQ-024 Override W=4, TOL=2 and drive 20 edges over a 40-cycle window -> beat_count saturates at 15, result=15, too_high=1.
REQ-025 Edges on the window_count=19 cycle and in the EVAL cycle -> the first counts in window N; the second gives beat_count=1 in window N+1.
REQ-026 Two control cases:
- enable dropped at window_count=7 -> IDLE, no result_valid, prior result held;
- reset pulsed for 3 ns mid-window with clk stopped -> all outputs at reset values immediately.
